// File: rtl/yuv444_to_422.sv
`default_nettype none
// ============================================================================
// yuv444_to_422 : packs 4:4:4 pixels into 16-bit 4:2:2 words {C,Y}
// Revision: 1.0
// ============================================================================
module yuv444_to_422 #(
  parameter int CHROMA_AVG = 1,
  parameter int XW         = 10
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [7:0]    iY,
  input  logic [7:0]    iCb,
  input  logic [7:0]    iCr,
  input  logic          iDVAL,
  input  logic          iSOL,
  output logic [15:0]   oYCbCr,
  output logic          oDVAL,
  output logic          oSOL,
  output logic [XW-1:0] oX
);

  logic        r_phaseOdd;
  logic        r_pending;
  logic        r_evenSol;
  logic [7:0]  r_evenY;
  logic [7:0]  r_evenCb;
  logic [7:0]  r_evenCr;
  logic        r_oddValid;
  logic [15:0] r_oddWord;

  logic [7:0]  w_cbPair;
  logic [7:0]  w_crPair;
  logic        w_acceptEven;
  logic        w_acceptOdd;
  logic        w_flush;

  // A line start always restarts the pair, regardless of the running phase.
  assign w_acceptEven = iDVAL & (iSOL | ~r_phaseOdd);
  assign w_acceptOdd  = iDVAL & ~iSOL & r_phaseOdd & r_pending;
  assign w_flush      = w_acceptEven & iSOL & r_pending;

  generate
    if (CHROMA_AVG != 0) begin : g_avg
      assign w_cbPair = 8'(({1'b0, r_evenCb} + {1'b0, iCb} + 9'd1) >> 1);
      assign w_crPair = 8'(({1'b0, r_evenCr} + {1'b0, iCr} + 9'd1) >> 1);
    end else begin : g_even
      assign w_cbPair = r_evenCb;
      assign w_crPair = r_evenCr;
    end
  endgenerate

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_phaseOdd <= 1'b0;
      r_pending  <= 1'b0;
      r_evenSol  <= 1'b0;
      r_evenY    <= 8'd0;
      r_evenCb   <= 8'd0;
      r_evenCr   <= 8'd0;
    end else if (iDVAL) begin
      r_phaseOdd <= w_acceptEven;
      if (w_acceptEven) begin
        r_pending <= 1'b1;
        r_evenSol <= iSOL;
        r_evenY   <= iY;
        r_evenCb  <= iCb;
        r_evenCr  <= iCr;
      end else if (w_acceptOdd) begin
        r_pending <= 1'b0;
      end
    end
  end

  // The odd slot drains the cycle after an odd accept, so it can never
  // coincide with another odd accept or with an orphan flush.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oYCbCr     <= 16'd0;
      oDVAL      <= 1'b0;
      oSOL       <= 1'b0;
      oX         <= '0;
      r_oddValid <= 1'b0;
      r_oddWord  <= 16'd0;
    end else begin
      r_oddValid <= w_acceptOdd;
      if (w_acceptOdd) begin
        oYCbCr    <= {w_crPair, r_evenY};
        oDVAL     <= 1'b1;
        oSOL      <= r_evenSol;
        oX        <= r_evenSol ? '0 : oX + 1'b1;
        r_oddWord <= {w_cbPair, iY};
      end else if (w_flush) begin
        oYCbCr <= {r_evenCr, r_evenY};
        oDVAL  <= 1'b1;
        oSOL   <= r_evenSol;
        oX     <= r_evenSol ? '0 : oX + 1'b1;
      end else if (r_oddValid) begin
        oYCbCr <= r_oddWord;
        oDVAL  <= 1'b1;
        oSOL   <= 1'b0;
        oX     <= oX + 1'b1;
      end else begin
        oDVAL <= 1'b0;
        oSOL  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_yuv444_to_422.sv
`default_nettype none
// ============================================================================
// tb_yuv444_to_422 : directed bench, averaging and even-chroma instances
// Revision: 1.0
// ============================================================================
module tb_yuv444_to_422;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [7:0]  iY, iCb, iCr;
  logic        iDVAL, iSOL;
  logic [15:0] yA, yB;
  logic        dvA, dvB, solA, solB;
  logic [9:0]  xA, xB;

  int nChecks = 0;
  int nPass   = 0;

  always #5 iCLK = ~iCLK;

  yuv444_to_422 #(.CHROMA_AVG(1), .XW(10)) dA (
    .iCLK(iCLK), .iRST_N(iRST_N), .iY(iY), .iCb(iCb), .iCr(iCr),
    .iDVAL(iDVAL), .iSOL(iSOL), .oYCbCr(yA), .oDVAL(dvA), .oSOL(solA), .oX(xA)
  );

  yuv444_to_422 #(.CHROMA_AVG(0), .XW(10)) dB (
    .iCLK(iCLK), .iRST_N(iRST_N), .iY(iY), .iCb(iCb), .iCr(iCr),
    .iDVAL(iDVAL), .iSOL(iSOL), .oYCbCr(yB), .oDVAL(dvB), .oSOL(solB), .oX(xB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Apply one input cycle, then return at the following negedge.
  task automatic cyc(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                     input logic dv, input logic sol);
    iY = y; iCb = cb; iCr = cr; iDVAL = dv; iSOL = sol;
    @(negedge iCLK);
  endtask

  task automatic word(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                      input logic es, input logic [9:0] ex);
    chk({tag, "_dvA"}, 32'(dvA), 32'(1));
    chk({tag, "_yA"}, 32'(yA), 32'(ea));
    chk({tag, "_yB"}, 32'(yB), 32'(eb));
    chk({tag, "_solA"}, 32'(solA), 32'(es));
    chk({tag, "_xA"}, 32'(xA), 32'(ex));
  endtask

  initial begin
    iRST_N = 1'b0;
    iY = 8'd0; iCb = 8'd0; iCr = 8'd0; iDVAL = 1'b0; iSOL = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("rst_y", 32'(yA), 32'(0));
    chk("rst_dv", 32'(dvA), 32'(0));
    chk("rst_sol", 32'(solA), 32'(0));
    chk("rst_x", 32'(xA), 32'(0));
    iRST_N = 1'b1;
    @(negedge iCLK);

    // Back-to-back pair, rounding on both chroma channels
    cyc(8'h10, 8'h80, 8'h40, 1'b1, 1'b1);
    chk("p1_nodv", 32'(dvA), 32'(0));
    cyc(8'h20, 8'h81, 8'h43, 1'b1, 1'b0);
    word("p1_even", 16'h4210, 16'h4010, 1'b1, 10'd0);
    cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    word("p1_odd", 16'h8120, 16'h8020, 1'b0, 10'd1);
    chk("p1_solB", 32'(solB), 32'(0));
    chk("p1_xB", 32'(xB), 32'(1));

    // Extreme chroma values
    cyc(8'h01, 8'hFF, 8'h00, 1'b1, 1'b1);
    chk("ext_nodv", 32'(dvA), 32'(0));
    cyc(8'h02, 8'hFF, 8'h01, 1'b1, 1'b0);
    word("ext_even", 16'h0101, 16'h0001, 1'b1, 10'd0);
    cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    word("ext_odd", 16'hFF02, 16'hFF02, 1'b0, 10'd1);

    // Three-pixel line, then a new line flushes the orphan
    cyc(8'h30, 8'h10, 8'h20, 1'b1, 1'b1);
    chk("l3_nodv", 32'(dvA), 32'(0));
    cyc(8'h31, 8'h12, 8'h22, 1'b1, 1'b0);
    word("l3_w0", 16'h2130, 16'h2030, 1'b1, 10'd0);
    cyc(8'h32, 8'h14, 8'h24, 1'b1, 1'b0);
    word("l3_w1", 16'h1131, 16'h1031, 1'b0, 10'd1);
    cyc(8'h55, 8'h11, 8'h22, 1'b1, 1'b1);
    word("l3_flush", 16'h2432, 16'h2432, 1'b0, 10'd2);
    cyc(8'h56, 8'h13, 8'h26, 1'b1, 1'b0);
    word("nl_w0", 16'h2455, 16'h2255, 1'b1, 10'd0);
    cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    word("nl_w1", 16'h1256, 16'h1156, 1'b0, 10'd1);

    // Gap between even and odd pixel; iSOL without iDVAL must be ignored
    cyc(8'h40, 8'h50, 8'h60, 1'b1, 1'b0);
    chk("gap_even_nodv", 32'(dvA), 32'(0));
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      chk("gap_idle_dv", 32'(dvA), 32'(0));
    end
    cyc(8'h41, 8'h52, 8'h62, 1'b1, 1'b0);
    word("gap_w0", 16'h6140, 16'h6040, 1'b0, 10'd2);
    cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    word("gap_w1", 16'h5141, 16'h5041, 1'b0, 10'd3);
    cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("hold_dv", 32'(dvA), 32'(0));
    chk("hold_y", 32'(yA), 32'(16'h5141));
    chk("hold_x", 32'(xA), 32'(3));

    // Reset between even and odd pixel
    cyc(8'h70, 8'h80, 8'h90, 1'b1, 1'b1);
    iDVAL = 1'b0;
    iRST_N = 1'b0;
    #1;
    chk("mrst_yA", 32'(yA), 32'(0));
    chk("mrst_yB", 32'(yB), 32'(0));
    chk("mrst_x", 32'(xA), 32'(0));
    chk("mrst_dv", 32'(dvA), 32'(0));
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    cyc(8'h71, 8'h81, 8'h91, 1'b1, 1'b0);
    chk("post_nodv0", 32'(dvA), 32'(0));
    cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("post_nodv1", 32'(dvA), 32'(0));
    cyc(8'h72, 8'h83, 8'h93, 1'b1, 1'b0);
    word("post_w0", 16'h9271, 16'h9171, 1'b0, 10'd1);
    cyc(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    word("post_w1", 16'h8272, 16'h8172, 1'b0, 10'd2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/yuv444_to_422.md
Name: yuv444_to_422

Overview:
- Packs a 4:4:4 pixel stream (separate Y, Cb, Cr bytes per pixel) into a 16-bit YUV 4:2:2 word stream.
- Chroma is decimated across horizontal even/odd pixel pairs, by averaging or by taking the even pixel's chroma.
- Sits on the output/store side of the processing chain, feeding SDRAM frame buffer or display paths that consume 4:2:2 words indexed by pixel X.
- The packed format is exactly what the 4:2:2→4:4:4 unpacker consumes: odd X carries {Cb,Y}, even X carries {Cr,Y}.

Parameters:
- CHROMA_AVG, 1: 1 = pair chroma is the rounded average of both pixels; 0 = pair chroma is the even pixel's Cb/Cr.
- XW, 10: width of the output pixel X counter.

Ports:
- iCLK  in  1  system clock, all logic on rising edge
- iRST_N  in  1  asynchronous active-low reset
- iY  in  8  input luma
- iCb  in  8  input blue chroma
- iCr  in  8  input red chroma
- iDVAL  in  1  input pixel valid; one pixel accepted per cycle when high
- iSOL  in  1  start of line; qualified by iDVAL; marks the first pixel of a line
- oYCbCr  out  16  packed word: [15:8] chroma, [7:0] luma
- oDVAL  out  1  output word valid
- oSOL  out  1  high with oDVAL on the first output word of a line
- oX  out  XW  X index of the current output word within the line

Behaviour:
- Reset (async, iRST_N low): oYCbCr=0, oDVAL=0, oSOL=0, oX=0; phase=even; pending-even flag=0; odd-slot flag=0. All registers are cleared at any time, including mid-pair or mid-line. A partially collected pair is discarded, never emitted.
- No backpressure. The sink always accepts. Output rate never exceeds input rate.
- Phase: an accepted pixel with iSOL=1 is always treated as even. Otherwise phase toggles on every accepted pixel.
- Even pixel accepted: store Y0, Cb0, Cr0, and the SOL flag; set pending. No output that cycle from this pixel.
- Odd pixel accepted (pending=1):
  - Compute C = CHROMA_AVG ? (a0+a1+1)>>1 using a 9-bit sum : a0, separately for Cb and Cr. The result never overflows 8 bits.
  - Next cycle: oDVAL=1, oYCbCr={Cr_pair,Y0}, oSOL=stored SOL, oX=even index.
  - Following cycle: oDVAL=1, oYCbCr={Cb_pair,Y1}, oSOL=0, oX=even index+1. This odd word is held in an odd-slot register.
  - Clear pending.
- Latency: even word appears 1 cycle after its odd partner is accepted; odd word appears 2 cycles after. With back-to-back input, output is continuous and each word lags its input pixel by 2 cycles.
- Orphan flush: iSOL accepted while pending=1 (odd-length previous line). Next cycle emit the stored even pixel alone as {Cr0,Y0}, chroma unfiltered, oSOL=its SOL flag. The new pixel becomes the pending even pixel. This never collides with the odd slot, because pending=1 implies the odd slot already drained.
- oX: loads 0 on any word with oSOL=1, otherwise increments on each oDVAL word. Wraps modulo 2^XW. Holds when oDVAL=0.
- oDVAL=0 cycles: oYCbCr and oX hold their last value. oSOL=0.
- iSOL with iDVAL=0 is ignored.
- Input gaps (iDVAL low) between even and odd pixels of a pair are allowed. Pending holds indefinitely.

Test Plan:
- Back-to-back pair with CHROMA_AVG=1, inputs at cycles 0 and 1, iSOL on the first: (Y,Cb,Cr)=(0x10,0x80,0x40),(0x20,0x81,0x43). Required: cycle 2 oYCbCr=0x4210, oSOL=1, oX=0; cycle 3 oYCbCr=0x8120, oX=1. Rounding: 0x42 from (0x40+0x43+1)>>1, and 0x81 from (0x80+0x81+1)>>1.
- Same stimulus with CHROMA_AVG=0 -> 0x4010 then 0x8020.
- Extreme values: Cb=0xFF,0xFF and Cr=0x00,0x01 -> Cb_pair=0xFF (no overflow), Cr_pair=0x01.
- 3-pixel line, then iSOL with a new pixel (Y=0x55, Cb=0x11, Cr=0x22) -> third pixel flushed as {Cr0,Y0} with oX=2. Next line's first word has oSOL=1 and oX=0.
- Input gaps: even pixel, 5 idle cycles, odd pixel -> words appear 1 and 2 cycles after the odd pixel. oDVAL=0 during the idle cycles.
- Assert iRST_N low between an even and an odd pixel -> all outputs 0 immediately. After release, a stray odd-phase pixel without iSOL is treated as a new even (phase reset), and no output occurs until its partner arrives.
